// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep checker for small combinational gates: drives every input vector in order and checks the gate output against EXP_TT.
// Optional feature: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_sweep_checker #(
  parameter int unsigned           N_IN   = 2,
  parameter int unsigned           SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT = 4'b1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_vld,
  output logic [N_IN-1:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          mismatch;
  logic          last;
  logic [N_IN:0] err_nxt;

  // Case-inequality so an X/Z gate output is treated as a mismatch in simulation.
  always_comb begin
    mismatch = (y_in !== EXP_TT[vec]);
    err_nxt  = err_cnt + (N_IN+1)'(mismatch);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    last     = (&vec) | mismatch;
`else
    last     = &vec;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vec      <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      fail_vld <= 1'b0;
      fail_vec <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SWEEP;
            vec      <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
            fail_vld <= 1'b0;
            fail_vec <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt == SETTLE_LAST) begin
            err_cnt <= err_nxt;
            if (mismatch && !fail_vld) begin
              fail_vld <= 1'b1;
              fail_vec <= vec;
            end
            // pass uses the post-sample count so the final vector is included.
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end else begin
              vec <= vec + N_IN'(1);
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker with default parameters (AND2 truth table, SETTLE=2).
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] vec;
  logic       y_in;
  logic       busy, done, pass, fail_vld;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0; // 0: AND2, 1: OR2, 2: AND2 with X on vector 3

  gate_sweep_checker #(.N_IN(2), .SETTLE(2), .EXP_TT(4'b1000)) dut (
    .clk(clk), .rst(rst), .start(start), .vec(vec), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_vld(fail_vld), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       y_in = vec[0] | vec[1];
      2:       y_in = (vec == 2'd3) ? 1'bx : (vec[0] & vec[1]);
      default: y_in = vec[0] & vec[1];
    endcase
  end

  // Returns just after edge k, the edge that samples start.
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({vec, busy, done, pass, err_cnt, fail_vld, fail_vec} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0b fvec=%0d, want all 0",
               vec, busy, done, pass, err_cnt, fail_vld, fail_vec);
    end
    rst = 1'b0;
  endtask

  task automatic test_and_sweep();
    mode = 0;
    do_start();
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_cmp++;
      if (vec !== ((j < 8) ? 2'(j / 2) : 2'd3)) begin
        n_bad++; $display("FAIL and_vec j=%0d: got %0d want %0d", j, vec, (j < 8) ? j / 2 : 3);
      end
      n_cmp++;
      if (done !== (j == 8) || busy !== (j < 8)) begin
        n_bad++; $display("FAIL and_done_busy j=%0d: got done=%0b busy=%0b want done=%0b busy=%0b",
                          j, done, busy, j == 8, j < 8);
      end
      if (j >= 8) begin
        n_cmp++;
        if (pass !== 1'b1 || err_cnt !== 3'd0 || fail_vld !== 1'b0) begin
          n_bad++; $display("FAIL and_result j=%0d: got pass=%0b err=%0d fv=%0b want 1/0/0", j, pass, err_cnt, fail_vld);
        end
      end
    end
  endtask

  task automatic test_or_sweep();
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    int last = 4; logic [1:0] vfin = 2'd1; logic [2:0] efin = 3'd1;
`else
    int last = 8; logic [1:0] vfin = 2'd3; logic [2:0] efin = 3'd2;
`endif
    mode = 1;
    do_start();
    for (int j = 0; j <= last; j++) begin
      @(negedge clk);
      n_cmp++;
      if (vec !== ((j < last) ? 2'(j / 2) : vfin)) begin
        n_bad++; $display("FAIL or_vec j=%0d: got %0d", j, vec);
      end
      n_cmp++;
      if (done !== (j == last)) begin
        n_bad++; $display("FAIL or_done j=%0d: got %0b want %0b", j, done, j == last);
      end
    end
    n_cmp++;
    if (err_cnt !== efin || fail_vld !== 1'b1 || fail_vec !== 2'd1 || pass !== 1'b0) begin
      n_bad++; $display("FAIL or_result: got err=%0d fv=%0b fvec=%0d pass=%0b want err=%0d fv=1 fvec=1 pass=0",
                        err_cnt, fail_vld, fail_vec, pass, efin);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    mode = 0;
    do_start();
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) ndone++;
      n_cmp++;
      if (done !== (j == 8) || busy !== (j < 8)) begin
        n_bad++; $display("FAIL ignore_sched j=%0d: got done=%0b busy=%0b want done=%0b busy=%0b",
                          j, done, busy, j == 8, j < 8);
      end
      start = (j == 3 || j == 8);
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 1) begin
      n_bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone);
    end
  endtask

  task automatic test_reset_mid();
    mode = 0;
    do_start();
    repeat (5) @(negedge clk);
    n_cmp++;
    if (vec !== 2'd2 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got vec=%0d busy=%0b want 2/1", vec, busy);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({vec, busy, done, pass, err_cnt, fail_vld, fail_vec} !== 11'd0) begin
      n_bad++; $display("FAIL mid_reset: got vec=%0d busy=%0b done=%0b pass=%0b err=%0d, want all 0",
                        vec, busy, done, pass, err_cnt);
    end
    #1 rst = 1'b0;
    do_start();
    repeat (9) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 3'd0 || vec !== 2'd3) begin
      n_bad++; $display("FAIL mid_rerun: got done=%0b pass=%0b err=%0d vec=%0d want 1/1/0/3", done, pass, err_cnt, vec);
    end
    @(negedge clk);
  endtask

  task automatic test_x_input();
    mode = 2;
    do_start();
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || fail_vld !== 1'b0) begin
      n_bad++; $display("FAIL x_pre: got busy=%0b fv=%0b want 1/0", busy, fail_vld);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || err_cnt !== 3'd1 || fail_vld !== 1'b1 || fail_vec !== 2'd3 || pass !== 1'b0) begin
      n_bad++; $display("FAIL x_result: got done=%0b err=%0d fv=%0b fvec=%0d pass=%0b want 1/1/1/3/0",
                        done, err_cnt, fail_vld, fail_vec, pass);
    end
    @(negedge clk);
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_or_sweep();
    test_start_ignored();
    test_reset_mid();
    test_x_input();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
